// File: rtl/ball_motion.sv
// Ball position, direction, scoring and game-state controller for the pong datapath.
// All outputs are registered so the edge/collision detector loop is broken here.
module ball_motion #(
   parameter int SPEED_X      = 2,
   parameter int SPEED_Y      = 1,
   parameter int PAUSE_FRAMES = 60,
   parameter int WIN_SCORE    = 9
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_tick,
   input  logic        start,
   input  logic [3:0]  ball_detect_edge,
   input  logic [7:0]  collision_detect,
   output logic [31:0] ball_off_x,
   output logic [31:0] ball_off_y,
   output logic        dir_x,
   output logic        dir_y,
   output logic [3:0]  score_L,
   output logic [3:0]  score_R,
   output logic        point_L,
   output logic        point_R,
   output logic        game_over
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PLAY,
      S_PAUSE,
      S_OVER
   } state_t;

   localparam int              CNT_W      = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES + 1) : 1;
   localparam logic [31:0]     STEP_X     = 32'(SPEED_X);
   localparam logic [31:0]     STEP_Y     = 32'(SPEED_Y);
   localparam logic [CNT_W-1:0] PAUSE_END = CNT_W'(PAUSE_FRAMES);
   localparam logic [3:0]      WIN        = 4'(WIN_SCORE);

   state_t            state_q, state_d;
   logic [31:0]       off_x_q, off_x_d;
   logic [31:0]       off_y_q, off_y_d;
   logic              dir_x_q, dir_x_d;
   logic              dir_y_q, dir_y_d;
   logic [3:0]        score_l_q, score_l_d;
   logic [3:0]        score_r_q, score_r_d;
   logic              point_l_q, point_l_d;
   logic              point_r_q, point_r_d;
   logic              game_over_q, game_over_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              hit_r, hit_l, wall_bot, wall_top, goal_l, goal_r;
   logic [3:0]        score_l_inc, score_r_inc;
   logic [CNT_W-1:0]  cnt_inc;
   logic              unused_cd;

   // Wall flags are active-low; a flag opposing the current direction is ignored.
   assign hit_r       = collision_detect[0] & collision_detect[2] & dir_x_q;
   assign hit_l       = collision_detect[1] & collision_detect[5] & ~dir_x_q;
   assign wall_bot    = ~ball_detect_edge[0] & dir_y_q;
   assign wall_top    = ~ball_detect_edge[2] & ~dir_y_q;
   assign goal_l      = ~ball_detect_edge[1] & ~hit_r & dir_x_q;
   assign goal_r      = ~ball_detect_edge[3] & ~hit_l & ~dir_x_q;
   assign score_l_inc = score_l_q + 4'd1;
   assign score_r_inc = score_r_q + 4'd1;
   assign cnt_inc     = cnt_q + 1'b1;
   assign unused_cd   = ^{collision_detect[7:6], collision_detect[4:3]};

   always_comb begin
      // NOTE: every target gets a default first so no path through the case infers a latch.
      state_d   = state_q;
      off_x_d   = off_x_q;
      off_y_d   = off_y_q;
      dir_x_d   = dir_x_q;
      dir_y_d   = dir_y_q;
      score_l_d = score_l_q;
      score_r_d = score_r_q;
      point_l_d = 1'b0;
      point_r_d = 1'b0;
      cnt_d     = cnt_q;

      unique case (state_q)
         S_IDLE: begin
            off_x_d = '0;
            off_y_d = '0;
            if (start) state_d = S_PLAY;
         end
         S_PLAY: begin
            if (frame_tick) begin
               if (hit_r)    dir_x_d = 1'b0;
               if (hit_l)    dir_x_d = 1'b1;
               if (wall_bot) dir_y_d = 1'b0;
               if (wall_top) dir_y_d = 1'b1;
               if (goal_l) begin
                  score_l_d = score_l_inc;
                  point_l_d = 1'b1;
                  dir_x_d   = 1'b0;
                  off_x_d   = '0;
                  off_y_d   = '0;
                  state_d   = (score_l_inc == WIN) ? S_OVER : S_PAUSE;
               end else if (goal_r) begin
                  score_r_d = score_r_inc;
                  point_r_d = 1'b1;
                  dir_x_d   = 1'b1;
                  off_x_d   = '0;
                  off_y_d   = '0;
                  state_d   = (score_r_inc == WIN) ? S_OVER : S_PAUSE;
               end else begin
                  // Motion uses the directions already updated by this tick's bounces.
                  off_x_d = dir_x_d ? off_x_q + STEP_X : off_x_q - STEP_X;
                  off_y_d = dir_y_d ? off_y_q + STEP_Y : off_y_q - STEP_Y;
               end
            end
         end
         S_PAUSE: begin
            off_x_d = '0;
            off_y_d = '0;
            if (frame_tick) begin
               if (cnt_inc == PAUSE_END) begin
                  cnt_d   = '0;
                  state_d = S_PLAY;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         S_OVER: begin
            if (start) begin
               score_l_d = '0;
               score_r_d = '0;
               off_x_d   = '0;
               off_y_d   = '0;
               cnt_d     = '0;
               dir_x_d   = 1'b1;
               dir_y_d   = 1'b1;
               state_d   = S_PLAY;
            end
         end
         default: state_d = S_IDLE;
      endcase

      game_over_d = (state_d == S_OVER);
   end

   always_ff @(posedge clk) begin
      // NOTE: state updates use non-blocking assignments; reset is sampled on the clock edge.
      if (!rst_n) begin
         state_q     <= S_IDLE;
         off_x_q     <= '0;
         off_y_q     <= '0;
         dir_x_q     <= 1'b1;
         dir_y_q     <= 1'b1;
         score_l_q   <= '0;
         score_r_q   <= '0;
         point_l_q   <= 1'b0;
         point_r_q   <= 1'b0;
         game_over_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         off_x_q     <= off_x_d;
         off_y_q     <= off_y_d;
         dir_x_q     <= dir_x_d;
         dir_y_q     <= dir_y_d;
         score_l_q   <= score_l_d;
         score_r_q   <= score_r_d;
         point_l_q   <= point_l_d;
         point_r_q   <= point_r_d;
         game_over_q <= game_over_d;
         cnt_q       <= cnt_d;
      end
   end

   assign ball_off_x = off_x_q;
   assign ball_off_y = off_y_q;
   assign dir_x      = dir_x_q;
   assign dir_y      = dir_y_q;
   assign score_L    = score_l_q;
   assign score_R    = score_r_q;
   assign point_L    = point_l_q;
   assign point_R    = point_r_q;
   assign game_over  = game_over_q;

endmodule
